// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the IF-stage program-counter generator.
// Holds the FSM state encoding, reset/trap defaults and the alignment-mask helper.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HOLD
   } state_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

   // All-ones except the log2(instr_bytes) LSBs; callers truncate to XLEN.
   function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
      return ~(64'(instr_bytes) - 64'd1);
   endfunction

endpackage

// File: rtl/pc_redirect_hold.sv
// Parks a redirect that arrived during a memory stall until the stall releases.
// Latency 1 cycle from capture/overwrite to outputs; no backpressure, latest load wins.
module pc_redirect_hold #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         capture,
   input  logic         overwrite,
   input  logic         clear,
   input  logic [W-1:0] target_in,
   output logic [W-1:0] target_out,
   output logic         pending
);

   logic [W-1:0] target_d, target_q;
   logic         pending_d, pending_q;

   always_comb begin
      target_d  = target_q;
      pending_d = pending_q;
      if (capture || overwrite) begin
         target_d = target_in;
      end
      if (capture) begin
         pending_d = 1'b1;
      end else if (clear) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         target_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         target_q  <= target_d;
         pending_q <= pending_d;
      end
   end

   assign target_out = target_q;
   assign pending    = pending_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, busywait freeze, redirect with stall capture.
// Latency 1 cycle input-to-pc_out; busywait holds the PC. Macro PC_GEN_MISALIGN_TRAP_EN adds misalign trap.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter int unsigned     INSTR_BYTES  = 4,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            busywait,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_next_seq,
   output logic            fetch_valid,
   output logic            flush_out,
`ifdef PC_GEN_MISALIGN_TRAP_EN
   output logic            misalign_err,
`endif
   output logic            redirect_pending
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INSTR_BYTES));
`ifdef PC_GEN_MISALIGN_TRAP_EN
   localparam bit          TRAP_EN = 1'b1;
   localparam int unsigned HOLD_W  = XLEN + 1;
`else
   localparam bit          TRAP_EN = 1'b0;
   localparam int unsigned HOLD_W  = XLEN;
`endif

   state_t          state_d, state_q;
   logic [XLEN-1:0] pc_d, pc_q;
   logic            fv_d, fv_q;
   logic            flush_d, flush_q;
   logic            redir_mis;
   logic [XLEN-1:0] redir_eff;
   logic            hold_capture, hold_overwrite, hold_clear;
   logic [HOLD_W-1:0] hold_in, hold_out;
   logic [XLEN-1:0] pend_target;

   assign redir_mis = |(redirect_target & ~ALIGN_MASK);
   assign redir_eff = (TRAP_EN && redir_mis) ? TRAP_VECTOR : (redirect_target & ALIGN_MASK);

   // The misalign verdict travels with the parked target so it pulses when applied.
`ifdef PC_GEN_MISALIGN_TRAP_EN
   logic err_d, err_q;
   logic pend_mis;
   assign hold_in     = {redir_mis, redir_eff};
   assign pend_mis    = hold_out[XLEN];
`else
   assign hold_in     = redir_eff;
`endif
   assign pend_target = hold_out[XLEN-1:0];

   pc_redirect_hold #(.W(HOLD_W)) u_hold (
      .clk        (clk),
      .rst        (rst),
      .capture    (hold_capture),
      .overwrite  (hold_overwrite),
      .clear      (hold_clear),
      .target_in  (hold_in),
      .target_out (hold_out),
      .pending    (redirect_pending)
   );

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      fv_d           = fv_q;
      flush_d        = 1'b0;
      hold_capture   = 1'b0;
      hold_overwrite = 1'b0;
      hold_clear     = 1'b0;
`ifdef PC_GEN_MISALIGN_TRAP_EN
      err_d          = 1'b0;
`endif
      case (state_q)
         ST_BOOT: begin
            fv_d    = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!busywait) begin
               if (redirect_valid) begin
                  pc_d    = redir_eff;
                  flush_d = 1'b1;
`ifdef PC_GEN_MISALIGN_TRAP_EN
                  err_d   = redir_mis;
`endif
               end else begin
                  pc_d = pc_next_seq;
               end
            end else if (redirect_valid) begin
               hold_capture = 1'b1;
               state_d      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (busywait) begin
               hold_overwrite = redirect_valid;
            end else begin
               pc_d       = redirect_valid ? redir_eff : pend_target;
               flush_d    = 1'b1;
               hold_clear = 1'b1;
               state_d    = ST_RUN;
`ifdef PC_GEN_MISALIGN_TRAP_EN
               err_d      = redirect_valid ? redir_mis : pend_mis;
`endif
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VECTOR;
         fv_q    <= 1'b0;
         flush_q <= 1'b0;
`ifdef PC_GEN_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fv_q    <= fv_d;
         flush_q <= flush_d;
`ifdef PC_GEN_MISALIGN_TRAP_EN
         err_q   <= err_d;
`endif
      end
   end

   assign pc_out      = pc_q;
   assign pc_next_seq = pc_q + XLEN'(INSTR_BYTES);
   assign fetch_valid = fv_q;
   assign flush_out   = flush_q;
`ifdef PC_GEN_MISALIGN_TRAP_EN
   assign misalign_err = err_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_pc_gen;

   localparam logic [31:0] RV = 32'h0000_1000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic        busywait;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] pc_out;
   logic [31:0] pc_next_seq;
   logic        fetch_valid;
   logic        flush_out;
   logic        redirect_pending;
`ifdef PC_GEN_MISALIGN_TRAP_EN
   logic        misalign_err;
`endif

   pc_gen #(
      .XLEN         (32),
      .RESET_VECTOR (RV),
      .INSTR_BYTES  (4),
      .TRAP_VECTOR  (TV)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .busywait         (busywait),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .pc_out           (pc_out),
      .pc_next_seq      (pc_next_seq),
      .fetch_valid      (fetch_valid),
      .flush_out        (flush_out),
`ifdef PC_GEN_MISALIGN_TRAP_EN
      .misalign_err     (misalign_err),
`endif
      .redirect_pending (redirect_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        fl;
      logic        pend;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   // Reference model: architectural view of the fetch unit.
   logic [31:0] m_pc   = RV;
   logic        m_fv   = 1'b0;
   logic        m_pend = 1'b0;
   logic [31:0] m_pt   = 32'h0;
   logic        m_pmis = 1'b0;

   function automatic bit is_mis(input logic [31:0] t);
      return (t % 4) != 0;
   endfunction

   function automatic logic [31:0] eff(input logic [31:0] t);
`ifdef PC_GEN_MISALIGN_TRAP_EN
      return is_mis(t) ? TV : t;
`else
      return t - (t % 4);
`endif
   endfunction

   function automatic bit mis_flag(input logic [31:0] t);
`ifdef PC_GEN_MISALIGN_TRAP_EN
      return is_mis(t);
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(input bit r, input bit bw, input bit rv, input logic [31:0] rt);
      exp_t e;
      @(negedge clk);
      rst = r; busywait = bw; redirect_valid = rv; redirect_target = rt;
      cyc++;
      e.fl = 1'b0; e.err = 1'b0;
      if (!r) begin
         m_pc = RV; m_fv = 1'b0; m_pend = 1'b0; m_pt = 32'h0; m_pmis = 1'b0;
      end else if (!m_fv) begin
         m_fv = 1'b1;
      end else if (!bw) begin
         if (rv) begin
            m_pc = eff(rt); e.fl = 1'b1; e.err = mis_flag(rt);
         end else if (m_pend) begin
            m_pc = m_pt; e.fl = 1'b1; e.err = m_pmis;
         end else begin
            m_pc = m_pc + 32'd4;
         end
         m_pend = 1'b0;
      end else if (rv) begin
         m_pt = eff(rt); m_pmis = mis_flag(rt); m_pend = 1'b1;
      end
      e.pc = m_pc; e.fv = m_fv; e.pend = m_pend; e.cyc = cyc;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_out", e.cyc, pc_out, e.pc);
            chk("pc_next_seq", e.cyc, pc_next_seq, e.pc + 32'd4);
            chk("fetch_valid", e.cyc, 32'(fetch_valid), 32'(e.fv));
            chk("flush_out", e.cyc, 32'(flush_out), 32'(e.fl));
            chk("redirect_pending", e.cyc, 32'(redirect_pending), 32'(e.pend));
`ifdef PC_GEN_MISALIGN_TRAP_EN
            chk("misalign_err", e.cyc, 32'(misalign_err), 32'(e.err));
`endif
         end
      end
   end

   initial begin
      logic [31:0] rt;
      rst = 1'b0; busywait = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

      // Reset, boot, sequential advance
      drive(0, 0, 0, 32'h0);
      drive(0, 1, 1, 32'h44);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 32'h0);

      // Unstalled redirects
      drive(1, 0, 1, 32'h20);
      drive(1, 0, 1, 32'h80);
      drive(1, 0, 0, 32'h0);
      drive(1, 0, 0, 32'h0);

      // Stalled redirects: latest wins, applied on release
      drive(1, 1, 1, 32'h40);
      drive(1, 1, 1, 32'h60);
      drive(1, 1, 0, 32'h0);
      drive(1, 0, 0, 32'h0);
      drive(1, 0, 0, 32'h0);
      // Redirect arriving on the release edge overrides the parked one
      drive(1, 1, 1, 32'h200);
      drive(1, 0, 1, 32'h300);
      drive(1, 0, 0, 32'h0);

      // Wrap-around
      drive(1, 0, 1, 32'hFFFF_FFFC);
      drive(1, 0, 0, 32'h0);
      drive(1, 0, 0, 32'h0);

      // Misaligned redirects, direct and stalled
      drive(1, 0, 1, 32'h82);
      drive(1, 0, 0, 32'h0);
      drive(1, 1, 1, 32'h1233);
      drive(1, 1, 0, 32'h0);
      drive(1, 0, 0, 32'h0);
      drive(1, 0, 0, 32'h0);

      // Reset during HOLD discards the parked target
      drive(1, 1, 1, 32'h500);
      drive(1, 1, 0, 32'h0);
      drive(0, 1, 0, 32'h0);
      drive(1, 1, 0, 32'h0);
      drive(1, 0, 0, 32'h0);
      drive(1, 0, 0, 32'h0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       rt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            1:       rt = 32'($urandom_range(0, 255));
            default: rt = $urandom;
         endcase
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0), rt);
      end
      drive(1, 0, 0, 32'h0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected responses left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
